// File: rtl/rob_commit_sched_pkg.sv
// rob_commit_sched_pkg
// Shared types and constants for the reorder-buffer commit scheduler.
// Contents:
//   DEF_ROB_WIDTH - default log2 of the ROB entry count
//   REG_ZERO      - architectural register x0 (never written)
//   rob_tag_t     - ROB tag at the default width
//   rob_entry_t   - one ROB entry (valid, ready, rd, val, mispredict, target)
package rob_commit_sched_pkg;

  localparam int DEF_ROB_WIDTH = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [DEF_ROB_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_sched_if.sv
// rob_commit_sched_if
// Bundles the issue, CDB, bypass-query and commit signals of the ROB
// scheduler.
// Modports:
//   master - the pipeline side (issue stage, CDB, bypass readers, regfile)
//   slave  - the ROB scheduler itself
interface rob_commit_sched_if
  #(parameter int ROB_WIDTH = rob_commit_sched_pkg::DEF_ROB_WIDTH);

  // Issue / allocation
  logic                 alloc_req;
  logic [4:0]           alloc_rd;
  logic                 alloc_gnt;
  logic [ROB_WIDTH-1:0] alloc_tag;
  logic                 full;

  // Common data bus
  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_tag;
  logic [31:0]          cdb_val;
  logic                 cdb_mispredict;
  logic [31:0]          cdb_target;

  // Operand bypass queries
  logic [ROB_WIDTH-1:0] qry1_tag;
  logic [ROB_WIDTH-1:0] qry2_tag;
  logic                 qry1_ready;
  logic                 qry2_ready;
  logic [31:0]          qry1_val;
  logic [31:0]          qry2_val;

  // Commit / flush
  logic                 commit_sig;
  logic [4:0]           commit_reg;
  logic [31:0]          commit_val;
  logic [ROB_WIDTH:0]   commit_rob_tag;
  logic                 clear;
  logic [31:0]          redirect_pc;

  modport master (
    output alloc_req, alloc_rd,
    output cdb_valid, cdb_tag, cdb_val, cdb_mispredict, cdb_target,
    output qry1_tag, qry2_tag,
    input  alloc_gnt, alloc_tag, full,
    input  qry1_ready, qry2_ready, qry1_val, qry2_val,
    input  commit_sig, commit_reg, commit_val, commit_rob_tag,
    input  clear, redirect_pc
  );

  modport slave (
    input  alloc_req, alloc_rd,
    input  cdb_valid, cdb_tag, cdb_val, cdb_mispredict, cdb_target,
    input  qry1_tag, qry2_tag,
    output alloc_gnt, alloc_tag, full,
    output qry1_ready, qry2_ready, qry1_val, qry2_val,
    output commit_sig, commit_reg, commit_val, commit_rob_tag,
    output clear, redirect_pc
  );

endinterface

// File: rtl/rob_entry_array.sv
// rob_entry_array
// Storage for the ROB entries.
// Write ports: alloc (tail), CDB result (ignored on invalid entries),
// retire invalidate (head), and a flush that clears every valid bit.
// Read ports (combinational): full head entry, plus two query ports that
// return valid/ready/val for a tag.
// Ports: clk, rst_n (async active-low), alloc_*, cdb_*, retire_*, flush,
//        head_idx/head_entry, qry1_*/qry2_*.
module rob_entry_array
  import rob_commit_sched_pkg::*;
#(
  parameter int ROB_WIDTH = DEF_ROB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_we,
  input  logic [ROB_WIDTH-1:0] alloc_idx,
  input  logic [4:0]           alloc_rd,
  input  logic                 cdb_we,
  input  logic [ROB_WIDTH-1:0] cdb_idx,
  input  logic [31:0]          cdb_val,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target,
  input  logic                 retire_we,
  input  logic [ROB_WIDTH-1:0] retire_idx,
  input  logic                 flush,
  input  logic [ROB_WIDTH-1:0] head_idx,
  output rob_entry_t           head_entry,
  input  logic [ROB_WIDTH-1:0] qry1_idx,
  output logic                 qry1_valid,
  output logic                 qry1_ready,
  output logic [31:0]          qry1_val,
  input  logic [ROB_WIDTH-1:0] qry2_idx,
  output logic                 qry2_valid,
  output logic                 qry2_ready,
  output logic [31:0]          qry2_val
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  rob_entry_t entries [DEPTH];

  // Alloc only ever targets an invalid slot and the CDB only writes valid
  // ones, so the two never collide on the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (cdb_we && entries[cdb_idx].valid) begin
        entries[cdb_idx].ready      <= 1'b1;
        entries[cdb_idx].val        <= cdb_val;
        entries[cdb_idx].mispredict <= cdb_mispredict;
        entries[cdb_idx].target     <= cdb_target;
      end
      if (retire_we) entries[retire_idx].valid <= 1'b0;
      if (alloc_we) begin
        entries[alloc_idx].valid      <= 1'b1;
        entries[alloc_idx].ready      <= 1'b0;
        entries[alloc_idx].mispredict <= 1'b0;
        entries[alloc_idx].rd         <= alloc_rd;
      end
    end
  end

  assign head_entry = entries[head_idx];

  assign qry1_valid = entries[qry1_idx].valid;
  assign qry1_ready = entries[qry1_idx].ready;
  assign qry1_val   = entries[qry1_idx].val;
  assign qry2_valid = entries[qry2_idx].valid;
  assign qry2_ready = entries[qry2_idx].ready;
  assign qry2_val   = entries[qry2_idx].val;

endmodule

// File: rtl/rob_commit_sched.sv
// rob_commit_sched
// Reorder-buffer scheduler: allocates tags at issue, collects CDB results,
// retires strictly in order onto the register-file commit port, and raises
// a one-cycle clear + redirect_pc when a mispredicted entry retires.
// Ports: clk, rst_n (async active-low), rdy (global enable),
//        bus (rob_commit_sched_if.slave: alloc, CDB, queries, commit, clear).
module rob_commit_sched
  import rob_commit_sched_pkg::*;
#(
  parameter int ROB_WIDTH = DEF_ROB_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  rob_commit_sched_if.slave bus
);

  localparam int                 DEPTH      = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] COUNT_FULL = (ROB_WIDTH+1)'(DEPTH);

  logic [ROB_WIDTH-1:0] head_ptr, tail_ptr;
  logic [ROB_WIDTH:0]   count;
  logic                 commit_sig_q, clear_q;
  logic [4:0]           commit_reg_q;
  logic [31:0]          commit_val_q, redirect_pc_q;
  logic [ROB_WIDTH:0]   commit_tag_q;

  rob_entry_t  head_entry;
  logic        q1_valid, q1_ready, q2_valid, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        active, retire, flush_now, alloc_gnt, full, q1_hit, q2_hit;

  // Retire looks only at the stored ready bit, so a CDB hit on the head
  // commits one cycle later. A retiring mispredict blocks allocation.
  assign active    = rdy && !clear_q;
  assign retire    = active && head_entry.valid && head_entry.ready;
  assign flush_now = retire && head_entry.mispredict;
  assign full      = (count == COUNT_FULL);
  assign alloc_gnt = bus.alloc_req && active && !full && !flush_now;

  rob_entry_array #(.ROB_WIDTH(ROB_WIDTH)) u_entries (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_we       (alloc_gnt),
    .alloc_idx      (tail_ptr),
    .alloc_rd       (bus.alloc_rd),
    .cdb_we         (bus.cdb_valid && active),
    .cdb_idx        (bus.cdb_tag),
    .cdb_val        (bus.cdb_val),
    .cdb_mispredict (bus.cdb_mispredict),
    .cdb_target     (bus.cdb_target),
    .retire_we      (retire),
    .retire_idx     (head_ptr),
    .flush          (flush_now),
    .head_idx       (head_ptr),
    .head_entry     (head_entry),
    .qry1_idx       (bus.qry1_tag),
    .qry1_valid     (q1_valid),
    .qry1_ready     (q1_ready),
    .qry1_val       (q1_val),
    .qry2_idx       (bus.qry2_tag),
    .qry2_valid     (q2_valid),
    .qry2_ready     (q2_ready),
    .qry2_val       (q2_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush_now) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (retire)    head_ptr <= head_ptr + 1'b1;
      if (alloc_gnt) tail_ptr <= tail_ptr + 1'b1;
      case ({alloc_gnt, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // With rdy=0 or clear=1, retire and flush_now are both low, so the two
  // pulses drop to 0 while the data registers hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_sig_q  <= 1'b0;
      commit_reg_q  <= '0;
      commit_val_q  <= '0;
      commit_tag_q  <= '0;
      clear_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      commit_sig_q <= retire && (head_entry.rd != REG_ZERO);
      clear_q      <= flush_now;
      if (retire) begin
        commit_reg_q <= head_entry.rd;
        commit_val_q <= head_entry.val;
        commit_tag_q <= {1'b0, head_ptr};
      end
      if (flush_now) redirect_pc_q <= head_entry.target;
    end
  end

  // A same-cycle CDB broadcast is forwarded to the bypass readers.
  assign q1_hit = bus.cdb_valid && (bus.cdb_tag == bus.qry1_tag);
  assign q2_hit = bus.cdb_valid && (bus.cdb_tag == bus.qry2_tag);

  assign bus.qry1_ready     = q1_valid && (q1_ready || q1_hit);
  assign bus.qry1_val       = q1_hit ? bus.cdb_val : q1_val;
  assign bus.qry2_ready     = q2_valid && (q2_ready || q2_hit);
  assign bus.qry2_val       = q2_hit ? bus.cdb_val : q2_val;

  assign bus.alloc_gnt      = alloc_gnt;
  assign bus.alloc_tag      = tail_ptr;
  assign bus.full           = full;
  assign bus.commit_sig     = commit_sig_q;
  assign bus.commit_reg     = commit_reg_q;
  assign bus.commit_val     = commit_val_q;
  assign bus.commit_rob_tag = commit_tag_q;
  assign bus.clear          = clear_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_rob_commit_sched.sv
// tb_rob_commit_sched
// Directed self-checking bench for rob_commit_sched with hand-computed
// expected values: in-order commit, full/wrap, rd=0 retire, mispredict
// flush, same-cycle query bypass, async reset and rdy stall.
module tb_rob_commit_sched;

  logic clk;
  logic rst_n;
  logic rdy;
  int   checks;
  int   errors;

  rob_commit_sched_if #(.ROB_WIDTH(4)) bus ();

  rob_commit_sched #(.ROB_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's worth of issue/CDB inputs and lets them settle.
  task automatic applyStimulus(input logic a_req, input logic [4:0] a_rd,
                               input logic c_v, input logic [3:0] c_tag,
                               input logic [31:0] c_val, input logic c_mis,
                               input logic [31:0] c_tgt);
    bus.alloc_req      = a_req;
    bus.alloc_rd       = a_rd;
    bus.cdb_valid      = c_v;
    bus.cdb_tag        = c_tag;
    bus.cdb_val        = c_val;
    bus.cdb_mispredict = c_mis;
    bus.cdb_target     = c_tgt;
    #1;
  endtask

  // Advances past the next rising edge, then drops the one-shot inputs.
  task automatic step();
    @(posedge clk);
    #1;
    bus.alloc_req = 1'b0;
    bus.cdb_valid = 1'b0;
    bus.cdb_mispredict = 1'b0;
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    bus.alloc_req = 1'b0;
    bus.cdb_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rdy = 1'b1;
    rst_n = 1'b0;
    bus.qry1_tag = '0;
    bus.qry2_tag = '0;
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    #1;

    // Reset state
    checkOutput("rst_commit_sig", 32'(bus.commit_sig), 32'd0);
    checkOutput("rst_clear", 32'(bus.clear), 32'd0);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    checkOutput("rst_redirect", bus.redirect_pc, 32'd0);
    checkOutput("rst_commit_val", bus.commit_val, 32'd0);
    resetDut();

    // In-order commit with out-of-order results
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      checkOutput("io_gnt", 32'(bus.alloc_gnt), 32'd1);
      checkOutput("io_tag", 32'(bus.alloc_tag), 32'(i));
      step();
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'h33, 1'b0, 32'h0);
    step();
    checkOutput("io_no_early_commit_a", 32'(bus.commit_sig), 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h11, 1'b0, 32'h0);
    step();
    checkOutput("io_no_early_commit_b", 32'(bus.commit_sig), 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h22, 1'b0, 32'h0);
    step();
    checkOutput("io_c0_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("io_c0_reg", 32'(bus.commit_reg), 32'd1);
    checkOutput("io_c0_val", bus.commit_val, 32'h11);
    checkOutput("io_c0_tag", 32'(bus.commit_rob_tag), 32'd0);
    step();
    checkOutput("io_c1_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("io_c1_reg", 32'(bus.commit_reg), 32'd2);
    checkOutput("io_c1_val", bus.commit_val, 32'h22);
    checkOutput("io_c1_tag", 32'(bus.commit_rob_tag), 32'd1);
    step();
    checkOutput("io_c2_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("io_c2_reg", 32'(bus.commit_reg), 32'd3);
    checkOutput("io_c2_val", bus.commit_val, 32'h33);
    checkOutput("io_c2_tag", 32'(bus.commit_rob_tag), 32'd2);
    step();
    checkOutput("io_idle_sig", 32'(bus.commit_sig), 32'd0);

    // Full boundary and tail wrap
    resetDut();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      checkOutput("fill_tag", 32'(bus.alloc_tag), 32'(i));
      step();
    end
    checkOutput("full_set", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 5'd20, 1'b1, 4'd0, 32'h77, 1'b0, 32'h0);
    checkOutput("gnt_when_full", 32'(bus.alloc_gnt), 32'd0);
    step();
    applyStimulus(1'b1, 5'd20, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    checkOutput("gnt_full_retiring", 32'(bus.alloc_gnt), 32'd0);
    step();
    checkOutput("full_ret_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("full_ret_val", bus.commit_val, 32'h77);
    checkOutput("full_cleared", 32'(bus.full), 32'd0);
    checkOutput("wrap_tag", 32'(bus.alloc_tag), 32'd0);
    applyStimulus(1'b1, 5'd21, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_gnt", 32'(bus.alloc_gnt), 32'd1);
    step();
    checkOutput("full_again", 32'(bus.full), 32'd1);

    // rd=0 retire produces no commit pulse but advances head
    resetDut();
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 5'd7, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h5, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h9, 1'b0, 32'h0);
    step();
    checkOutput("rd0_sig", 32'(bus.commit_sig), 32'd0);
    checkOutput("rd0_tag", 32'(bus.commit_rob_tag), 32'd0);
    step();
    checkOutput("rd0_next_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("rd0_next_reg", 32'(bus.commit_reg), 32'd7);
    checkOutput("rd0_next_val", bus.commit_val, 32'h9);
    checkOutput("rd0_next_tag", 32'(bus.commit_rob_tag), 32'd1);

    // Mispredict retire: commit, clear, redirect, flush
    resetDut();
    applyStimulus(1'b1, 5'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 5'd3, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 5'd4, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0); step();
    applyStimulus(1'b1, 5'd5, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0); step();
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'hA0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h44, 1'b1, 32'h1000);
    step();
    checkOutput("mp_pre_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("mp_pre_reg", 32'(bus.commit_reg), 32'd2);
    checkOutput("mp_pre_clear", 32'(bus.clear), 32'd0);
    applyStimulus(1'b1, 5'd9, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    checkOutput("gnt_masked_flush", 32'(bus.alloc_gnt), 32'd0);
    step();
    checkOutput("mp_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("mp_reg", 32'(bus.commit_reg), 32'd1);
    checkOutput("mp_val", bus.commit_val, 32'h44);
    checkOutput("mp_tag", 32'(bus.commit_rob_tag), 32'd1);
    checkOutput("mp_clear", 32'(bus.clear), 32'd1);
    checkOutput("mp_redirect", bus.redirect_pc, 32'h1000);
    checkOutput("mp_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    checkOutput("mp_full", 32'(bus.full), 32'd0);
    applyStimulus(1'b1, 5'd9, 1'b1, 4'd3, 32'h55, 1'b0, 32'h0);
    checkOutput("gnt_during_clear", 32'(bus.alloc_gnt), 32'd0);
    step();
    checkOutput("mp_clear_drop", 32'(bus.clear), 32'd0);
    checkOutput("mp_sig_drop", 32'(bus.commit_sig), 32'd0);
    checkOutput("mp_alloc_tag_after", 32'(bus.alloc_tag), 32'd0);
    bus.qry1_tag = 4'd3;
    #1;
    checkOutput("mp_late_cdb_ignored", 32'(bus.qry1_ready), 32'd0);
    step();
    checkOutput("mp_no_stray_commit", 32'(bus.commit_sig), 32'd0);

    // Query bypass on a same-cycle CDB hit, then from storage
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'(i + 10), 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      step();
    end
    bus.qry1_tag = 4'd5;
    bus.qry2_tag = 4'd4;
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd5, 32'hABCD, 1'b0, 32'h0);
    checkOutput("qry_bypass_ready", 32'(bus.qry1_ready), 32'd1);
    checkOutput("qry_bypass_val", bus.qry1_val, 32'hABCD);
    checkOutput("qry2_not_ready", 32'(bus.qry2_ready), 32'd0);
    step();
    checkOutput("qry_stored_ready", 32'(bus.qry1_ready), 32'd1);
    checkOutput("qry_stored_val", bus.qry1_val, 32'hABCD);
    bus.qry2_tag = 4'd9;
    #1;
    checkOutput("qry_invalid_entry", 32'(bus.qry2_ready), 32'd0);

    // Async reset mid-stream discards everything with no commit pulse
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h10, 1'b0, 32'h0); step();
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h20, 1'b0, 32'h0); step();
    checkOutput("pre_rst_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("pre_rst_val", bus.commit_val, 32'h10);
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'h30, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sig", 32'(bus.commit_sig), 32'd0);
    checkOutput("async_rst_val", bus.commit_val, 32'd0);
    checkOutput("async_rst_reg", 32'(bus.commit_reg), 32'd0);
    checkOutput("async_rst_qry", 32'(bus.qry1_ready), 32'd0);
    step();
    checkOutput("rst_hold_sig", 32'(bus.commit_sig), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_tag", 32'(bus.alloc_tag), 32'd0);

    // rdy=0 freezes retirement
    applyStimulus(1'b1, 5'd3, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0); step();
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h99, 1'b0, 32'h0); step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd4, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      checkOutput("stall_gnt", 32'(bus.alloc_gnt), 32'd0);
      step();
      checkOutput("stall_sig", 32'(bus.commit_sig), 32'd0);
    end
    rdy = 1'b1;
    step();
    checkOutput("unstall_sig", 32'(bus.commit_sig), 32'd1);
    checkOutput("unstall_reg", 32'(bus.commit_reg), 32'd3);
    checkOutput("unstall_val", bus.commit_val, 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
